bcd_to_bin: RTL and testbench



---
 rtl/bcd_to_bin.sv | 144 ++++++++++++++
 tb/tb_bcd_to_bin.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
// Each iteration shifts the combined {bcd, binary} register right by one,
// then pulls every BCD nibble that reads >= 8 back down by 3. After BIN_W
// iterations the binary field holds the value and the BCD field is empty.
// Level start / ready handshake: ready stays high in DONE until start drops.
module bcd_to_bin #(
    parameter int NDIGITS = 4,
    parameter int BIN_W   = 14,
    parameter int DP_W    = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [4*NDIGITS-1:0]   bcd,
    output logic [BIN_W-1:0]       binary,
    output logic                   ovf,
    output logic                   err,
    output logic                   ready
);

    localparam int BCD_W = 4 * NDIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_W);
    // Largest value the downstream datapath can carry.
    localparam logic [63:0]      DP_MAX   = (64'd1 << DP_W) - 64'd1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        SUB3  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state;
    logic [SR_W-1:0]    sr;
    logic [CNT_W-1:0]   cnt;

    // Per-nibble correction after a right shift: a digit that picked up the
    // weight-8 bit from its upper neighbour really gained 5, not 8, so take 3
    // back. No borrow crosses nibble boundaries.
    function automatic logic [BCD_W-1:0] sub3_all(input logic [BCD_W-1:0] field);
        logic [BCD_W-1:0] res;
        logic [3:0]       nib;
        res = field;
        for (int i = 0; i < NDIGITS; i++) begin
            nib = field[4*i +: 4];
            if (nib >= 4'd8) begin
                nib = nib - 4'd3;
            end
            res[4*i +: 4] = nib;
        end
        return res;
    endfunction

    // True when any nibble of the packed input is not a decimal digit.
    function automatic logic bad_digit(input logic [BCD_W-1:0] field);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (field[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // True when the converted value does not fit the DP_W-bit datapath.
    function automatic logic exceeds_dp(input logic [BIN_W-1:0] value);
        return 64'(value) > DP_MAX;
    endfunction

    // Conversion FSM with registered result and handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            sr     <= '0;
            cnt    <= '0;
            binary <= '0;
            ovf    <= 1'b0;
            err    <= 1'b0;
            ready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b0;
                    if (start) begin
                        state <= LOAD;
                    end
                end

                LOAD: begin
                    sr  <= {bcd, {BIN_W{1'b0}}};
                    cnt <= CNT_INIT;
                    if (bad_digit(bcd)) begin
                        binary <= '0;
                        ovf    <= 1'b0;
                        err    <= 1'b1;
                        ready  <= 1'b1;
                        state  <= DONE;
                    end else begin
                        state <= SHIFT;
                    end
                end

                SHIFT: begin
                    sr    <= sr >> 1;
                    cnt   <= cnt - 1'b1;
                    state <= SUB3;
                end

                SUB3: begin
                    sr[SR_W-1:BIN_W] <= sub3_all(sr[SR_W-1:BIN_W]);
                    if (cnt == '0) begin
                        binary <= sr[BIN_W-1:0];
                        ovf    <= exceeds_dp(sr[BIN_W-1:0]);
                        err    <= 1'b0;
                        ready  <= 1'b1;
                        state  <= DONE;
                    end else begin
                        state <= SHIFT;
                    end
                end

                DONE: begin
                    if (start) begin
                        ready <= 1'b1;
                    end else begin
                        ready <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Testbench for bcd_to_bin: directed boundary cases plus randomized
// conversions, checked every cycle against a decimal-arithmetic model.
module tb_bcd_to_bin;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] bcd = 16'h0000;
    logic [13:0] binary;
    logic        ovf;
    logic        err;
    logic        ready;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 0;

    bcd_to_bin #(.NDIGITS(4), .BIN_W(14), .DP_W(12)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .bcd    (bcd),
        .binary (binary),
        .ovf    (ovf),
        .err    (err),
        .ready  (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal meaning of a packed BCD word: digit-by-digit base-10 sum.
    task automatic ref_convert(input logic [15:0] v, output int val, output bit bad);
        int d;
        val = 0;
        bad = 0;
        for (int i = 3; i >= 0; i--) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) bad = 1;
            val = val * 10 + d;
        end
    endtask

    // Behavioural model: protocol phases with a fixed busy time; the result
    // is the decimal value of bcd captured on the edge after start is taken.
    typedef enum {M_IDLE, M_CAPT, M_BUSY, M_DONE} mode_t;
    mode_t m = M_IDLE;
    int    rem = 0;
    int    pend = 0;
    int    r_val;
    bit    r_bad;
    int    e_bin = 0;
    bit    e_ovf = 0, e_err = 0, e_rdy = 0;

    always @(posedge clk) begin
        if (reset) begin
            m = M_IDLE; e_bin = 0; e_ovf = 0; e_err = 0; e_rdy = 0;
        end else begin
            case (m)
                M_IDLE: begin
                    e_rdy = 0;
                    if (start) m = M_CAPT;
                end
                M_CAPT: begin
                    ref_convert(bcd, r_val, r_bad);
                    if (r_bad) begin
                        e_bin = 0; e_ovf = 0; e_err = 1; e_rdy = 1; m = M_DONE;
                    end else begin
                        pend = r_val; rem = 28; m = M_BUSY;
                    end
                end
                M_BUSY: begin
                    rem--;
                    if (rem == 0) begin
                        e_bin = pend; e_ovf = (pend > 4095); e_err = 0; e_rdy = 1;
                        m = M_DONE;
                    end
                end
                M_DONE: begin
                    if (!start) begin
                        e_rdy = 0; m = M_IDLE;
                    end
                end
                default: m = M_IDLE;
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_ready",  32'(ready),  32'(e_rdy));
            check("cyc_binary", 32'(binary), 32'(e_bin));
            check("cyc_ovf",    32'(ovf),    32'(e_ovf));
            check("cyc_err",    32'(err),    32'(e_err));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One handshake: raise start with v, count edges until ready, keep start
    // high for 'hold' more cycles, then drop it for one edge.
    task automatic run_conv(input logic [15:0] v, input int hold, input bit change_mid,
                            output int lat);
        bcd   = v;
        start = 1'b1;
        lat   = 0;
        do begin
            step(1);
            lat++;
            if (change_mid && lat == 2) bcd = 16'($urandom);
        end while (!ready && lat < 100);
        if (!ready) check("ready_timeout", 32'(ready), 32'd1);
        step(hold);
        start = 1'b0;
        step(1);
    endtask

    int lat;
    int rv;
    bit rb;
    logic [15:0] v;

    initial begin
        step(2);
        cmp_en = 1;
        check("rst_binary", 32'(binary), 32'd0);
        check("rst_ready",  32'(ready),  32'd0);
        check("rst_ovf",    32'(ovf),    32'd0);
        check("rst_err",    32'(err),    32'd0);
        reset = 1'b0;
        step(1);

        run_conv(16'h1234, 0, 0, lat);
        check("lat_1234", 32'(lat), 32'd30);
        check("bin_1234", 32'(binary), 32'd1234);
        check("ovf_1234", 32'(ovf), 32'd0);
        check("rdy_drop", 32'(ready), 32'd0);

        run_conv(16'h4095, 0, 0, lat);
        check("bin_4095", 32'(binary), 32'd4095);
        check("ovf_4095", 32'(ovf), 32'd0);

        run_conv(16'h4096, 0, 0, lat);
        check("bin_4096", 32'(binary), 32'd4096);
        check("ovf_4096", 32'(ovf), 32'd1);

        run_conv(16'h9999, 0, 0, lat);
        check("bin_9999", 32'(binary), 32'h270F);
        check("ovf_9999", 32'(ovf), 32'd1);

        run_conv(16'h0000, 0, 0, lat);
        check("bin_0000", 32'(binary), 32'd0);
        check("err_0000", 32'(err), 32'd0);

        run_conv(16'h12A4, 0, 0, lat);
        check("lat_12A4", 32'(lat), 32'd2);
        check("err_12A4", 32'(err), 32'd1);
        check("bin_12A4", 32'(binary), 32'd0);

        run_conv(16'h0007, 0, 0, lat);
        check("err_0007", 32'(err), 32'd0);
        check("bin_0007", 32'(binary), 32'd7);

        // Long start hold after ready, with bcd disturbed mid-conversion.
        run_conv(16'h0555, 10, 1, lat);
        check("bin_hold", 32'(binary), 32'd555);

        // Reset during a conversion.
        bcd = 16'h9999;
        start = 1'b1;
        step(12);
        start = 1'b0;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("rstmid_binary", 32'(binary), 32'd0);
        check("rstmid_ready",  32'(ready),  32'd0);
        run_conv(16'h0042, 0, 0, lat);
        check("lat_0042", 32'(lat), 32'd30);
        check("bin_0042", 32'(binary), 32'd42);

        // Back-to-back: start falls one cycle after ready, rises next cycle.
        run_conv(16'h0321, 1, 0, lat);
        run_conv(16'h0789, 0, 0, lat);
        check("bin_b2b", 32'(binary), 32'd789);
        check("lat_b2b", 32'(lat), 32'd30);

        // Randomized conversions, some with a non-decimal nibble.
        for (int k = 0; k < 25; k++) begin
            v = 16'h0000;
            for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 4) == 0) v[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            ref_convert(v, rv, rb);
            run_conv(v, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), lat);
            check("rnd_lat", 32'(lat), rb ? 32'd2 : 32'd30);
        end

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
